nonce_scheduler: RTL and testbench

//  Sweeps a nonce range over the SHA-256 mining datapath (FSM + preprocessing + chunk engine).
//  For each nonce it issues one core run and waits for the core's done strobe.
//  It then checks the returned 256-bit hash against a leading-zero difficulty.
//  It stops on the first hit, on range exhaustion, on core timeout or on abort.

---
 rtl/nonce_scheduler_if.sv | 43 ++++
 rtl/nonce_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_nonce_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nonce_scheduler_if.sv
// Host/control and mining-core signals of the nonce sweep sequencer.
// slave = the scheduler itself; master = host plus core (or a bench standing in for both).
interface nonce_scheduler_if #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256,
    parameter int DIFF_W  = 9
);
    // host control
    logic               start;
    logic               abort;
    logic [NONCE_W-1:0] nonce_start;
    logic [NONCE_W-1:0] nonce_end;
    logic [DIFF_W-1:0]  difficulty;

    // mining core
    logic               core_start;
    logic [NONCE_W-1:0] core_nonce;
    logic               core_done;
    logic [HASH_W-1:0]  core_hash;

    // status
    logic               busy;
    logic               done;
    logic               found;
    logic               exhausted;
    logic               timeout_err;
    logic [NONCE_W-1:0] golden_nonce;
    logic [NONCE_W:0]   attempts;

    modport slave (
        input  start, abort, nonce_start, nonce_end, difficulty,
        input  core_done, core_hash,
        output core_start, core_nonce,
        output busy, done, found, exhausted, timeout_err, golden_nonce, attempts
    );

    modport master (
        output start, abort, nonce_start, nonce_end, difficulty,
        output core_done, core_hash,
        input  core_start, core_nonce,
        input  busy, done, found, exhausted, timeout_err, golden_nonce, attempts
    );
endinterface

// File: rtl/nonce_scheduler.sv
// Sequencer sweeping a nonce range over the mining core, stopping on hit/exhaustion/timeout/abort.
// Latency: ISSUE(1) + core latency + CHECK(1) per nonce; DONE pulse one cycle after the last CHECK.
// Backpressure: one core run outstanding at a time; start ignored unless idle, abort wins everywhere.
module nonce_scheduler #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256,
    parameter int DIFF_W  = 9,
    parameter int TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    nonce_scheduler_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int CLZ_W = $clog2(HASH_W + 1);
    localparam int CMP_W = (CLZ_W > DIFF_W) ? CLZ_W : DIFF_W;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DIFF_W-1:0] DIFF_MAX  = DIFF_W'(HASH_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [NONCE_W-1:0] cur;
    logic [NONCE_W-1:0] end_q;
    logic [DIFF_W-1:0]  diff_q;
    logic [HASH_W-1:0]  hash_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_inc;
    logic [NONCE_W:0]   attempts_q;
    logic [NONCE_W-1:0] golden_q;
    logic               found_q;
    logic               exhausted_q;
    logic               timeout_q;

    logic [CLZ_W-1:0]   clz;
    logic               hit;

    logic               ld_start;
    logic               take_hash;
    logic               set_found;
    logic               set_exh;
    logic               set_timeout;
    logic               bump_cur;

    function automatic logic [CLZ_W-1:0] count_lz(input logic [HASH_W-1:0] h);
        logic [CLZ_W-1:0] n;
        logic             seen;
        n    = '0;
        seen = 1'b0;
        for (int i = HASH_W - 1; i >= 0; i--) begin
            if (h[i]) begin
                seen = 1'b1;
            end else if (!seen) begin
                n = n + 1'b1;
            end
        end
        return n;
    endfunction

    assign clz      = count_lz(hash_q);
    assign hit      = CMP_W'(clz) >= CMP_W'(diff_q);
    assign wait_inc = wait_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        ld_start    = 1'b0;
        take_hash   = 1'b0;
        set_found   = 1'b0;
        set_exh     = 1'b0;
        set_timeout = 1'b0;
        bump_cur    = 1'b0;
        if (bus.abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        ld_start = 1'b1;
                        state_n  = S_ISSUE;
                    end
                end
                S_ISSUE: state_n = S_WAIT;
                S_WAIT: begin
                    if (bus.core_done) begin
                        take_hash = 1'b1;
                        state_n   = S_CHECK;
                    end else if (wait_inc == WAIT_LAST) begin
                        // fires so the fault flag lands exactly TIMEOUT cycles after core_start
                        set_timeout = 1'b1;
                        state_n     = S_DONE;
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        set_found = 1'b1;
                        state_n   = S_DONE;
                    end else if (cur == end_q) begin
                        set_exh = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        bump_cur = 1'b1;
                        state_n  = S_ISSUE;
                    end
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur         <= '0;
            end_q       <= '0;
            diff_q      <= '0;
            hash_q      <= '0;
            wait_cnt    <= '0;
            attempts_q  <= '0;
            golden_q    <= '0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (ld_start) begin
                cur         <= bus.nonce_start;
                end_q       <= bus.nonce_end;
                diff_q      <= (bus.difficulty > DIFF_MAX) ? DIFF_MAX : bus.difficulty;
                attempts_q  <= '0;
                golden_q    <= '0;
                found_q     <= 1'b0;
                exhausted_q <= 1'b0;
                timeout_q   <= 1'b0;
            end
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_inc;
            end
            if (take_hash) begin
                hash_q     <= bus.core_hash;
                attempts_q <= attempts_q + 1'b1;
            end
            if (set_found) begin
                found_q  <= 1'b1;
                golden_q <= cur;
            end
            if (set_exh) begin
                exhausted_q <= 1'b1;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
            // natural width overflow gives the wrap from all-ones back to zero
            if (bump_cur) begin
                cur <= cur + 1'b1;
            end
        end
    end

    assign bus.core_start   = (state == S_ISSUE);
    assign bus.core_nonce   = cur;
    assign bus.busy         = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
    assign bus.done         = (state == S_DONE);
    assign bus.found        = found_q;
    assign bus.exhausted    = exhausted_q;
    assign bus.timeout_err  = timeout_q;
    assign bus.golden_nonce = golden_q;
    assign bus.attempts     = attempts_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: host driver, behavioural mining core and nonce scoreboard.
module tb_nonce_scheduler;

    localparam int NONCE_W = 32;
    localparam int HASH_W  = 256;
    localparam int DIFF_W  = 9;
    localparam int TIMEOUT = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    nonce_scheduler_if #(.NONCE_W(NONCE_W), .HASH_W(HASH_W), .DIFF_W(DIFF_W)) bus ();

    nonce_scheduler #(
        .NONCE_W(NONCE_W), .HASH_W(HASH_W), .DIFF_W(DIFF_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int spurious = 0;
    int last_start_cyc = 0;
    logic [31:0] exp_q[$];

    // core model knobs
    bit          core_en = 1'b1;
    int          core_lat = 0;
    bit          hit_en = 1'b0;
    logic [31:0] hit_n = '0;
    int          hit_lz = 0;
    int          miss_lz = 0;
    logic [31:0] model_n;
    int          model_lat;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lz_for(input logic [31:0] n);
        return (hit_en && n == hit_n) ? hit_lz : miss_lz;
    endfunction

    function automatic logic [HASH_W-1:0] hash_for(input logic [31:0] n);
        logic [HASH_W-1:0] ones;
        int lz;
        ones = '1;
        lz = lz_for(n);
        if (lz >= HASH_W) return '0;
        return ones >> lz;
    endfunction

    // expected nonce order, stopping at the first hit or at the inclusive end
    task automatic push_seq(input logic [31:0] s, input logic [31:0] e, input logic [8:0] d,
                            input int max_n);
        logic [31:0] n;
        int dc;
        n = s;
        dc = (d > 9'd256) ? 256 : int'(d);
        for (int i = 0; i < max_n; i++) begin
            exp_q.push_back(n);
            if (lz_for(n) >= dc || n == e) break;
            n = n + 32'd1;
        end
    endtask

    // behavioural core: one run per core_start, done after core_lat (or random) cycles
    initial begin
        bus.core_done = 1'b0;
        bus.core_hash = '0;
        forever begin
            @(negedge clock);
            if (bus.core_start && core_en) begin
                model_n   = bus.core_nonce;
                model_lat = (core_lat > 0) ? core_lat : int'($urandom_range(1, 4));
                repeat (model_lat) @(negedge clock);
                bus.core_done = 1'b1;
                bus.core_hash = hash_for(model_n);
                @(negedge clock);
                bus.core_done = 1'b0;
                bus.core_hash = '0;
            end
        end
    end

    always @(negedge clock) begin
        if (bus.core_start) begin
            start_cnt++;
            last_start_cyc = cyc;
            if (exp_q.size() == 0) spurious++;
            else check_val("core_nonce", {32'd0, bus.core_nonce}, {32'd0, exp_q.pop_front()});
        end
        if (bus.done) done_cnt++;
    end

    task automatic launch(input logic [31:0] s, input logic [31:0] e, input logic [8:0] d);
        @(negedge clock);
        bus.start = 1'b1;
        bus.nonce_start = s;
        bus.nonce_end = e;
        bus.difficulty = d;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (bus.done) begin
                at = cyc;
                break;
            end
        end
        #1;
        check_val("done_seen", (at >= 0), 1);
    endtask

    task automatic wait_starts(input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            #1;
            if (start_cnt >= target) break;
        end
        check_val("start_count", start_cnt, target);
    endtask

    task automatic check_end(input string tag, input bit f, input bit x, input bit t, input int att);
        check_val({tag, ".found"}, bus.found, f);
        check_val({tag, ".exhausted"}, bus.exhausted, x);
        check_val({tag, ".timeout_err"}, bus.timeout_err, t);
        check_val({tag, ".attempts"}, bus.attempts, att);
        check_val({tag, ".busy"}, bus.busy, 0);
        check_val({tag, ".queue_left"}, exp_q.size(), 0);
        check_val({tag, ".spurious"}, spurious, 0);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".core_start"}, bus.core_start, 0);
        check_val({tag, ".core_nonce"}, bus.core_nonce, 0);
        check_val({tag, ".busy"}, bus.busy, 0);
        check_val({tag, ".done"}, bus.done, 0);
        check_val({tag, ".flags"}, {bus.found, bus.exhausted, bus.timeout_err}, 0);
        check_val({tag, ".golden"}, bus.golden_nonce, 0);
        check_val({tag, ".attempts"}, bus.attempts, 0);
    endtask

    initial begin
        int at;
        int d0;
        int s0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.nonce_start = '0;
        bus.nonce_end = '0;
        bus.difficulty = '0;

        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;

        // T1 hit on 0x13; neighbours sit one zero short of the difficulty
        hit_en = 1'b1; hit_n = 32'h13; hit_lz = 8; miss_lz = 7;
        push_seq(32'h10, 32'h1F, 9'd8, 64);
        d0 = done_cnt; s0 = start_cnt;
        launch(32'h10, 32'h1F, 9'd8);
        wait_done(200, at);
        check_end("t1", 1'b1, 1'b0, 1'b0, 4);
        check_val("t1.golden", bus.golden_nonce, 32'h13);
        check_val("t1.starts", start_cnt - s0, 4);
        @(negedge clock);
        #1;
        check_val("t1.done_width", bus.done, 0);
        check_val("t1.done_pulses", done_cnt - d0, 1);
        check_val("t1.found_sticky", bus.found, 1);

        // T2 exhaust with difficulty 256 and hashes of 255 leading zeros
        hit_en = 1'b0; miss_lz = 255;
        push_seq(32'd0, 32'd3, 9'd256, 64);
        launch(32'd0, 32'd3, 9'd256);
        wait_done(200, at);
        check_end("t2", 1'b0, 1'b1, 1'b0, 4);

        // T3 wrap through all-ones
        miss_lz = 0;
        push_seq(32'hFFFF_FFFE, 32'h0000_0001, 9'd8, 64);
        launch(32'hFFFF_FFFE, 32'h0000_0001, 9'd8);
        wait_done(200, at);
        check_end("t3", 1'b0, 1'b1, 1'b0, 4);

        // T4 silent core
        core_en = 1'b0;
        push_seq(32'd5, 32'd9, 9'd8, 1);
        d0 = done_cnt;
        launch(32'd5, 32'd9, 9'd8);
        wait_done(TIMEOUT + 50, at);
        check_val("t4.latency", at - last_start_cyc, TIMEOUT);
        check_end("t4", 1'b0, 1'b0, 1'b1, 0);
        check_val("t4.done_pulses", done_cnt - d0, 1);
        core_en = 1'b1;
        repeat (4) @(negedge clock);

        // T5 abort in the second WAIT, stray core_done afterwards
        core_lat = 3;
        push_seq(32'h40, 32'h4F, 9'd8, 2);
        d0 = done_cnt; s0 = start_cnt;
        launch(32'h40, 32'h4F, 9'd8);
        wait_starts(s0 + 2, 50);
        @(negedge clock);
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        check_val("t5.idle_busy", bus.busy, 0);
        check_val("t5.idle_core_start", bus.core_start, 0);
        repeat (8) @(negedge clock);
        #1;
        check_end("t5", 1'b0, 1'b0, 1'b0, 1);
        check_val("t5.done_pulses", done_cnt - d0, 0);

        // T6a reset in WAIT
        push_seq(32'h100, 32'h1FF, 9'd8, 1);
        s0 = start_cnt;
        launch(32'h100, 32'h1FF, 9'd8);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_zero("t6a");
        reset = 1'b0;
        repeat (8) @(negedge clock);
        #1;
        check_val("t6a.starts", start_cnt - s0, 1);
        check_end("t6a", 1'b0, 1'b0, 1'b0, 0);

        // T6b difficulty 0 hits immediately
        core_lat = 0;
        push_seq(32'h77, 32'h80, 9'd0, 64);
        launch(32'h77, 32'h80, 9'd0);
        wait_done(200, at);
        check_end("t6b", 1'b1, 1'b0, 1'b0, 1);
        check_val("t6b.golden", bus.golden_nonce, 32'h77);

        // T6c start while busy is ignored
        push_seq(32'h200, 32'h202, 9'd8, 64);
        launch(32'h200, 32'h202, 9'd8);
        @(negedge clock);
        bus.start = 1'b1;
        bus.nonce_start = 32'h999;
        bus.nonce_end = 32'h999;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(200, at);
        check_end("t6c", 1'b0, 1'b1, 1'b0, 3);

        // abort and start together in IDLE: start ignored, sticky flags untouched
        repeat (2) @(negedge clock);
        s0 = start_cnt;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.nonce_start = 32'h500;
        bus.nonce_end = 32'h500;
        @(negedge clock);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        check_val("t6d.starts", start_cnt - s0, 0);
        check_end("t6d", 1'b0, 1'b1, 1'b0, 3);

        // T7 difficulty above 256 clamps; all-zero hash counts 256 zeros
        hit_en = 1'b1; hit_n = 32'd2; hit_lz = 256; miss_lz = 255;
        push_seq(32'd0, 32'd5, 9'd300, 64);
        launch(32'd0, 32'd5, 9'd300);
        wait_done(200, at);
        check_end("t7", 1'b1, 1'b0, 1'b0, 3);
        check_val("t7.golden", bus.golden_nonce, 32'd2);

        repeat (4) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
